z80fi_insn_capture: RTL and testbench
=====================================

Name: z80fi_insn_capture

Overview:
- Upstream producer of the Z80 formal interface (z80fi) record consumed by every z80fi_insn_spec_* checker.
- Watches core retirement hooks, collects up to 4 opcode bytes per instruction, and snapshots the register file at instruction start (_in) and at retire (_out).
- Emits one registered, single-cycle z80fi_valid record per retired instruction.

Parameters:
- MAX_LEN, 4, maximum instruction bytes captured (Z80 worst case: prefix + prefix + disp + opcode).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- core_insn_start  in  1  pulse: first opcode fetch (M1) of a new instruction
- core_byte_valid  in  1  pulse: an instruction byte is fetched this cycle
- core_byte  in  8  instruction byte value
- core_insn_done  in  1  pulse: current instruction retires this cycle
- core_regs  in  128  live register file {iy,ix,ip,sp,hl,de,bc,af}, 16 bits each, af in [15:0]
- z80fi_valid  out  1  one-cycle record-valid strobe
- z80fi_insn  out  32  instruction bytes; byte0 in [7:0], byte1 in [15:8], and so on; unused bytes zero
- z80fi_insn_len  out  3  bytes captured, 1..4
- z80fi_regs_in  out  128  register snapshot at start, same packing as core_regs
- z80fi_regs_out  out  128  register snapshot at retire, same packing
- z80fi_error  out  1  sticky protocol error flag

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0, state is IDLE, and byte count is 0.
  - Reset mid-COLLECT discards the partial record, and no valid is emitted.
- States:
  - IDLE: waiting for core_insn_start.
  - COLLECT: gathering bytes until core_insn_done.
- IDLE to COLLECT on core_insn_start:
  - Latch core_regs into the in-snapshot register.
  - Clear the byte buffer.
  - Count = 0.
- Byte capture:
  - On core_byte_valid in COLLECT, or in the same cycle as core_insn_start, write core_byte at buffer[count] and increment count.
  - The byte arriving in the start cycle is byte0.
- Overflow: a byte arriving while count == MAX_LEN is dropped, count saturates at 4, and z80fi_error is set.
- Retire, on core_insn_done in COLLECT:
  - A byte in the same cycle is included.
  - core_regs is sampled as the out-snapshot.
  - Next cycle: z80fi_valid = 1 for exactly one cycle, z80fi_insn, z80fi_insn_len and both snapshots present the record, and state returns to IDLE.
- Latency: valid is exactly 1 cycle after core_insn_done.
- Record outputs hold their value after valid drops, until the next record. Checkers sample only on z80fi_valid.
- Back-to-back, core_insn_done and core_insn_start in the same cycle:
  - The old record is emitted next cycle.
  - The new instruction's in-snapshot is taken from the same core_regs sample used for the old out-snapshot.
  - State stays COLLECT.
  - A byte that cycle belongs to the new instruction.
- Error cases, each sets z80fi_error:
  - core_insn_done in IDLE (without start): ignored, no valid.
  - core_insn_start in COLLECT without done: the partial record is aborted (no valid) and capture restarts.
  - Retire with count == 0: record emitted with len 0.
- z80fi_error clears only on reset.
- Output unpacking: the 128-bit snapshot buses are split into the named z80fi_reg_*_in/_out signals by the Z80FI wrapper. The 8-bit halves are taken from the pair bytes; for example, b is bc[15:8].

Optional Feature:
- Z80FI_ORDER_EN
  - Defined: adds output z80fi_order [63:0], a retirement index.
    - Reset 0.
    - Presented with each record and incremented after each emitted valid.
    - The first record after reset carries order 0.
    - Aborted records do not consume an index.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- INC BC: start + byte 0x03, bc=0x1234, done 1 cycle later with bc=0x1235 -> the next cycle valid=1 for one cycle, insn=0x00000003, len=1, regs_in bc=0x1234, regs_out bc=0x1235, error=0.
- LD IX,0x1234: bytes 0xDD,0x21,0x34,0x12 over 4 cycles, done on the last byte -> insn=0x123421DD, len=4, regs_out ix=0x1234.
- Back-to-back: INC DE retire coincides with start of DEC HL (byte 0x2B) -> two valids in consecutive records; the second record's regs_in equals the first record's regs_out; insn=0x0000002B.
- Overflow: 5 bytes 0xDD,0xCB,0x05,0x06,0x77 then done -> insn=0x0605CBDD, len=4, error=1 sticky.
- Reset mid-COLLECT after 2 bytes, then a fresh INC SP (0x33), sp=0xFFFF -> only one valid, insn=0x33, regs_out sp=0x0000, error=0.
- With Z80FI_ORDER_EN: 3 instructions plus one aborted start -> orders 0, 1, 2; error=1.

Source files
------------

// File: rtl/z80fi_insn_capture_if.sv
// z80fi_insn_capture_if
// Groups the core retirement hooks and the z80fi record bus that
// z80fi_insn_capture sits between.
//   core_*    : driven by the core (or a bench), observed by the capture block
//   z80fi_*   : record bus produced by the capture block
//   dbg_state : capture FSM state (0 = IDLE, 1 = COLLECT) for checkers
// Optional macro Z80FI_ORDER_EN adds the 64-bit z80fi_order retirement index.
// Handshake: there is no back-pressure. The core_* pulses are single-cycle
// and are sampled on every rising clk edge. z80fi_valid is a one-cycle strobe,
// and the record fields are meaningful while it is high.
interface z80fi_insn_capture_if;
  logic         core_insn_start;
  logic         core_byte_valid;
  logic [7:0]   core_byte;
  logic         core_insn_done;
  logic [127:0] core_regs;

  logic         z80fi_valid;
  logic [31:0]  z80fi_insn;
  logic [2:0]   z80fi_insn_len;
  logic [127:0] z80fi_regs_in;
  logic [127:0] z80fi_regs_out;
  logic         z80fi_error;
`ifdef Z80FI_ORDER_EN
  logic [63:0]  z80fi_order;
`endif
  logic         dbg_state;

  modport master (
    output core_insn_start, core_byte_valid, core_byte, core_insn_done, core_regs,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in, z80fi_regs_out,
           z80fi_error,
`ifdef Z80FI_ORDER_EN
           z80fi_order,
`endif
           dbg_state
  );

  modport slave (
    input  core_insn_start, core_byte_valid, core_byte, core_insn_done, core_regs,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in, z80fi_regs_out,
           z80fi_error,
`ifdef Z80FI_ORDER_EN
           z80fi_order,
`endif
           dbg_state
  );
endinterface

// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture
// Builds one z80fi record per retired Z80 instruction. The block collects up
// to MAX_LEN opcode bytes and snapshots the register file at start (_in) and
// at retire (_out). The record is presented with a single-cycle z80fi_valid,
// one cycle after core_insn_done.
// Ports:
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : z80fi_insn_capture_if.slave (core hooks in, record out, dbg_state)
// Optional macro Z80FI_ORDER_EN adds the z80fi_order retirement index.
// Protocol errors set the sticky z80fi_error flag. They are: done while idle,
// start while collecting without done, a byte beyond MAX_LEN, and a retire
// with no bytes.
module z80fi_insn_capture #(
  parameter int MAX_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  z80fi_insn_capture_if.slave   bus
);
  localparam logic [2:0] LP_MAX = 3'(MAX_LEN);

  typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

  state_t         r_state;
  logic [2:0]     r_count;
  logic [31:0]    r_buf;
  logic [127:0]   r_snap_in;

  logic           r_valid;
  logic [31:0]    r_insn;
  logic [2:0]     r_len;
  logic [127:0]   r_regs_in;
  logic [127:0]   r_regs_out;
  logic           r_error;
`ifdef Z80FI_ORDER_EN
  logic [63:0]    r_order;
  logic [63:0]    r_order_next;
`endif

  logic           w_collect;
  logic           w_retire;
  logic           w_old_byte;
  logic           w_full;
  logic [31:0]    w_old_buf;
  logic [2:0]     w_old_cnt;
  logic [31:0]    w_new_buf;
  logic [2:0]     w_new_cnt;
  logic           w_err_set;

  assign w_collect  = (r_state == ST_COLLECT);
  assign w_retire   = w_collect & bus.core_insn_done;
  // A byte in a start cycle always belongs to the new instruction, even
  // when the old one retires in the same cycle.
  assign w_old_byte = w_collect & bus.core_byte_valid & ~bus.core_insn_start;
  assign w_full     = (r_count == LP_MAX);

  // Buffer and count of the instruction in flight, including this cycle's byte.
  always_comb begin
    w_old_buf = r_buf;
    w_old_cnt = r_count;
    if (w_old_byte && !w_full) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i == int'(r_count)) w_old_buf[i*8 +: 8] = bus.core_byte;
      end
      w_old_cnt = r_count + 3'd1;
    end
  end

  // A fresh instruction starts from an empty buffer; a start-cycle byte is byte0.
  assign w_new_buf = bus.core_byte_valid ? {24'h0, bus.core_byte} : 32'h0;
  assign w_new_cnt = {2'b00, bus.core_byte_valid};

  assign w_err_set = (w_old_byte & w_full)
                   | (~w_collect & bus.core_insn_done & ~bus.core_insn_start)
                   | (w_collect & bus.core_insn_start & ~bus.core_insn_done)
                   | (w_retire & (w_old_cnt == 3'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_count      <= 3'd0;
      r_buf        <= 32'h0;
      r_snap_in    <= 128'h0;
      r_valid      <= 1'b0;
      r_insn       <= 32'h0;
      r_len        <= 3'd0;
      r_regs_in    <= 128'h0;
      r_regs_out   <= 128'h0;
      r_error      <= 1'b0;
`ifdef Z80FI_ORDER_EN
      r_order      <= 64'h0;
      r_order_next <= 64'h0;
`endif
    end else begin
      r_valid <= w_retire;
      if (w_retire) begin
        r_insn     <= w_old_buf;
        r_len      <= w_old_cnt;
        r_regs_in  <= r_snap_in;
        r_regs_out <= bus.core_regs;
`ifdef Z80FI_ORDER_EN
        r_order      <= r_order_next;
        r_order_next <= r_order_next + 64'd1;
`endif
      end

      if (w_err_set) r_error <= 1'b1;

      if (bus.core_insn_start) begin
        // Covers a new start from idle, a back-to-back start and an abort.
        // The in-snapshot shares the core_regs sample used for any out-snapshot.
        r_state   <= ST_COLLECT;
        r_snap_in <= bus.core_regs;
        r_buf     <= w_new_buf;
        r_count   <= w_new_cnt;
      end else if (w_retire) begin
        r_state <= ST_IDLE;
        r_buf   <= 32'h0;
        r_count <= 3'd0;
      end else if (w_collect) begin
        r_buf   <= w_old_buf;
        r_count <= w_old_cnt;
      end
    end
  end

  assign bus.z80fi_valid    = r_valid;
  assign bus.z80fi_insn     = r_insn;
  assign bus.z80fi_insn_len = r_len;
  assign bus.z80fi_regs_in  = r_regs_in;
  assign bus.z80fi_regs_out = r_regs_out;
  assign bus.z80fi_error    = r_error;
`ifdef Z80FI_ORDER_EN
  assign bus.z80fi_order    = r_order;
`endif
  assign bus.dbg_state      = r_state;
endmodule

// File: tb/tb_z80fi_insn_capture.sv
// tb_z80fi_insn_capture
// Bench for z80fi_insn_capture. A reference model keeps the instruction in
// flight as a byte queue and pushes finished records onto exp_q. A compare
// process checks the DUT against it every cycle. Directed sequences pin
// literal values, and a randomized phase follows.
// Also builds with Z80FI_ORDER_EN defined.
module tb_z80fi_insn_capture;
  localparam int W = 355;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  z80fi_insn_capture_if bus ();

  z80fi_insn_capture #(.MAX_LEN(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard and model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rec = '0;
  logic [7:0]   m_bytes[$];
  logic         m_active = 1'b0;
  logic [127:0] m_in = '0;
  logic         m_err = 1'b0;
  logic [63:0]  m_order = '0;
  logic         exp_valid = 1'b0;
  logic         chk_en = 1'b0;

  // Scratch variables for stimulus
  logic         rs, rbv, rd;
  logic [7:0]   rb;
  logic [127:0] rr, rx, ry;

  function automatic logic [W-1:0] pack_rec(input logic [31:0] insn, input logic [2:0] len,
                                            input logic [127:0] ri, input logic [127:0] ro,
                                            input logic [63:0] ord);
    return {ord, ro, ri, len, insn};
  endfunction

  // Register file packing {iy,ix,ip,sp,hl,de,bc,af}
  function automatic logic [127:0] mk(input logic [15:0] bc, input logic [15:0] de,
                                      input logic [15:0] hl, input logic [15:0] sp,
                                      input logic [15:0] ix);
    return {16'h0, ix, 16'h0, sp, hl, de, bc, 16'h0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_append(input logic [7:0] b);
    if (m_bytes.size() < 4) m_bytes.push_back(b);
    else m_err = 1'b1;
  endtask

  // Computes the effect of one cycle of inputs: what is visible after the next edge.
  task automatic model_step(input logic s, input logic bv, input logic [7:0] b,
                            input logic d, input logic [127:0] regs);
    logic [31:0] ins;
    exp_valid = 1'b0;
    if (m_active && d) begin
      if (bv && !s) model_append(b);
      if (m_bytes.size() == 0) m_err = 1'b1;
      ins = '0;
      foreach (m_bytes[i]) ins[8*i +: 8] = m_bytes[i];
      exp_q.push_back(pack_rec(ins, 3'(m_bytes.size()), m_in, regs, m_order));
      m_order++;
      exp_valid = 1'b1;
      m_active = 1'b0;
    end else if (!m_active && d && !s) begin
      m_err = 1'b1;
    end
    if (s) begin
      if (m_active) m_err = 1'b1;
      m_active = 1'b1;
      m_bytes.delete();
      m_in = regs;
      if (bv) m_bytes.push_back(b);
    end else if (m_active && bv) begin
      model_append(b);
    end
  endtask

  // Called at a falling edge. Drives one cycle of inputs, then returns at
  // the next falling edge.
  task automatic cycle(input logic s, input logic bv, input logic [7:0] b,
                       input logic d, input logic [127:0] regs);
    bus.core_insn_start = s;
    bus.core_byte_valid = bv;
    bus.core_byte       = b;
    bus.core_insn_done  = d;
    bus.core_regs       = regs;
    model_step(s, bv, b, d, regs);
    @(negedge clk);
  endtask

  // Called at a falling edge. The reset lands asynchronously, mid-cycle.
  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    bus.core_insn_start = 1'b0;
    bus.core_byte_valid = 1'b0;
    bus.core_byte       = 8'h0;
    bus.core_insn_done  = 1'b0;
    bus.core_regs       = '0;
    m_active = 1'b0; m_err = 1'b0; m_order = '0; m_bytes.delete();
    exp_q.delete(); exp_valid = 1'b0; last_rec = '0;
    #1;
    chk("rst_valid", 128'(bus.z80fi_valid), 128'(1'b0));
    chk("rst_insn", 128'(bus.z80fi_insn), 128'(32'h0));
    chk("rst_len", 128'(bus.z80fi_insn_len), 128'(3'h0));
    chk("rst_regs_in", bus.z80fi_regs_in, 128'h0);
    chk("rst_regs_out", bus.z80fi_regs_out, 128'h0);
    chk("rst_error", 128'(bus.z80fi_error), 128'(1'b0));
    chk("rst_state", 128'(bus.dbg_state), 128'(1'b0));
`ifdef Z80FI_ORDER_EN
    chk("rst_order", 128'(bus.z80fi_order), 128'(64'h0));
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
  endtask

  // Per-cycle compare against the model. Record fields are checked every
  // cycle, so the check also covers holding after valid drops.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("valid", 128'(bus.z80fi_valid), 128'(exp_valid));
      chk("error", 128'(bus.z80fi_error), 128'(m_err));
      chk("state", 128'(bus.dbg_state), 128'(m_active));
      if (exp_valid && exp_q.size() > 0) last_rec = exp_q.pop_front();
      chk("insn", 128'(bus.z80fi_insn), 128'(last_rec[31:0]));
      chk("len", 128'(bus.z80fi_insn_len), 128'(last_rec[34:32]));
      chk("regs_in", bus.z80fi_regs_in, last_rec[162:35]);
      chk("regs_out", bus.z80fi_regs_out, last_rec[290:163]);
`ifdef Z80FI_ORDER_EN
      chk("order", 128'(bus.z80fi_order), 128'(last_rec[354:291]));
`endif
    end
  end

  initial begin
    bus.core_insn_start = 1'b0;
    bus.core_byte_valid = 1'b0;
    bus.core_byte       = 8'h0;
    bus.core_insn_done  = 1'b0;
    bus.core_regs       = '0;
    @(negedge clk);
    do_reset();

    // INC BC
    cycle(1'b1, 1'b1, 8'h03, 1'b0, mk(16'h1234, 16'h0, 16'h0, 16'h0, 16'h0));
    cycle(1'b0, 1'b0, 8'h00, 1'b1, mk(16'h1235, 16'h0, 16'h0, 16'h0, 16'h0));
    chk("incbc_valid", 128'(bus.z80fi_valid), 128'(1'b1));
    chk("incbc_insn", 128'(bus.z80fi_insn), 128'(32'h00000003));
    chk("incbc_len", 128'(bus.z80fi_insn_len), 128'(3'd1));
    chk("incbc_bc_in", 128'(bus.z80fi_regs_in[31:16]), 128'(16'h1234));
    chk("incbc_bc_out", 128'(bus.z80fi_regs_out[31:16]), 128'(16'h1235));
    chk("incbc_err", 128'(bus.z80fi_error), 128'(1'b0));
    cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);
    chk("incbc_drop", 128'(bus.z80fi_valid), 128'(1'b0));
    chk("incbc_hold", 128'(bus.z80fi_insn), 128'(32'h00000003));

    // LD IX,0x1234
    cycle(1'b1, 1'b1, 8'hDD, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h21, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h34, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h12, 1'b1, mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h1234));
    chk("ldix_insn", 128'(bus.z80fi_insn), 128'(32'h123421DD));
    chk("ldix_len", 128'(bus.z80fi_insn_len), 128'(3'd4));
    chk("ldix_ix_out", 128'(bus.z80fi_regs_out[111:96]), 128'(16'h1234));

    // Back-to-back: INC DE retires as DEC HL starts
    rx = mk(16'h0, 16'h1001, 16'h5000, 16'h0, 16'h0);
    ry = mk(16'h0, 16'h1001, 16'h4FFF, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 8'h13, 1'b0, mk(16'h0, 16'h1000, 16'h5000, 16'h0, 16'h0));
    cycle(1'b1, 1'b1, 8'h2B, 1'b1, rx);
    chk("b2b1_valid", 128'(bus.z80fi_valid), 128'(1'b1));
    chk("b2b1_insn", 128'(bus.z80fi_insn), 128'(32'h00000013));
    chk("b2b1_out", bus.z80fi_regs_out, rx);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, ry);
    chk("b2b2_valid", 128'(bus.z80fi_valid), 128'(1'b1));
    chk("b2b2_insn", 128'(bus.z80fi_insn), 128'(32'h0000002B));
    chk("b2b2_in", bus.z80fi_regs_in, rx);
    chk("b2b2_err", 128'(bus.z80fi_error), 128'(1'b0));

    // Overflow: fifth byte dropped
    cycle(1'b1, 1'b1, 8'hDD, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'hCB, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h05, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h06, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h77, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
    chk("ovf_insn", 128'(bus.z80fi_insn), 128'(32'h0605CBDD));
    chk("ovf_len", 128'(bus.z80fi_insn_len), 128'(3'd4));
    chk("ovf_err", 128'(bus.z80fi_error), 128'(1'b1));
    cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);
    chk("ovf_sticky", 128'(bus.z80fi_error), 128'(1'b1));

    // Reset mid-COLLECT, then INC SP
    cycle(1'b1, 1'b1, 8'hDD, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h09, 1'b0, '0);
    do_reset();
    cycle(1'b1, 1'b1, 8'h33, 1'b0, mk(16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0));
    cycle(1'b0, 1'b0, 8'h00, 1'b1, mk(16'h0, 16'h0, 16'h0, 16'h0000, 16'h0));
    chk("incsp_insn", 128'(bus.z80fi_insn), 128'(32'h00000033));
    chk("incsp_sp_in", 128'(bus.z80fi_regs_in[79:64]), 128'(16'hFFFF));
    chk("incsp_sp_out", 128'(bus.z80fi_regs_out[79:64]), 128'(16'h0000));
    chk("incsp_err", 128'(bus.z80fi_error), 128'(1'b0));

    // Three records plus one abort; the abort takes no index
    do_reset();
    cycle(1'b1, 1'b1, 8'h00, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
`ifdef Z80FI_ORDER_EN
    chk("order0", 128'(bus.z80fi_order), 128'(64'd0));
`endif
    cycle(1'b1, 1'b1, 8'h3C, 1'b0, '0);
    cycle(1'b1, 1'b1, 8'h3D, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
    chk("abort_insn", 128'(bus.z80fi_insn), 128'(32'h0000003D));
`ifdef Z80FI_ORDER_EN
    chk("order1", 128'(bus.z80fi_order), 128'(64'd1));
`endif
    cycle(1'b1, 1'b1, 8'h04, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
`ifdef Z80FI_ORDER_EN
    chk("order2", 128'(bus.z80fi_order), 128'(64'd2));
`endif
    chk("abort_err", 128'(bus.z80fi_error), 128'(1'b1));

    // Retire with no bytes gives len 0 and sets error
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
    chk("empty_valid", 128'(bus.z80fi_valid), 128'(1'b1));
    chk("empty_len", 128'(bus.z80fi_insn_len), 128'(3'd0));
    chk("empty_err", 128'(bus.z80fi_error), 128'(1'b1));

    // Done while idle: no valid, error
    do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
    chk("idle_done_valid", 128'(bus.z80fi_valid), 128'(1'b0));
    chk("idle_done_err", 128'(bus.z80fi_error), 128'(1'b1));

    // Randomized phase
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k == 300) do_reset();
      rs  = m_active ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      rd  = m_active ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rbv = 1'($urandom_range(0, 1));
      rb  = 8'($urandom);
      rr  = {$urandom, $urandom, $urandom, $urandom};
      cycle(rs, rbv, rb, rd, rr);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
